// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: pulses the PLL reset, filters the synchronised lock, stages the output-clock
// enables, and recovers from lock loss or lock timeout with a bounded number of retries.
module pll_lock_sequencer #(
    parameter int unsigned NUM_CLK      = 5,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_FILT    = 64,
    parameter int unsigned STAGE_GAP    = 8,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                             clkin_i,
    input  logic                             reset_i,
    input  logic                             pll_lock_i,
    input  logic                             restart_i,
    input  logic [NUM_CLK-1:0]               en_mask_i,
    output logic                             pll_reset_o,
    output logic [NUM_CLK-1:0]               enclk_o,
    output logic                             sys_rst_o,
    output logic                             clk_rdy_o,
    output logic                             fail_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o
);

    localparam int unsigned RCW = $clog2(RST_CYCLES) + 1;
    localparam int unsigned FCW = $clog2(LOCK_FILT) + 1;
    localparam int unsigned GCW = $clog2(STAGE_GAP) + 1;
    localparam int unsigned TCW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned SW  = $clog2(NUM_CLK) + 1;
    localparam int unsigned RTW = $clog2(MAX_RETRY + 1);

    localparam logic [RCW-1:0] RstLast  = RCW'(RST_CYCLES - 1);
    localparam logic [FCW-1:0] FiltLast = FCW'(LOCK_FILT - 1);
    localparam logic [GCW-1:0] GapLast  = GCW'(STAGE_GAP - 1);
    localparam logic [TCW-1:0] TmoLast  = TCW'(LOCK_TIMEOUT - 1);
    localparam logic [TCW-1:0] TmoMax   = TCW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0]  StLast   = SW'(NUM_CLK - 1);
    localparam logic [RTW-1:0] RetryMax = RTW'(MAX_RETRY);

    typedef enum logic [2:0] {StRstPll, StWaitLock, StFilter, StEnable, StRun, StFail} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, lock_s_q;
    logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [FCW-1:0]       filt_q, filt_d;
    logic [GCW-1:0]       gap_q, gap_d;
    logic [TCW-1:0]       tmo_q, tmo_d, tmo_inc;
    logic [SW-1:0]        stage_q, stage_d;
    logic [NUM_CLK-1:0]   staged_q, staged_d, mask_q, mask_d;
    logic [RTW-1:0]       retry_q, retry_d, retry_inc;
    logic                 go_enable;
    logic                 pll_reset_q, pll_reset_d, sys_rst_q, sys_rst_d;
    logic                 clk_rdy_q, clk_rdy_d, fail_q, fail_d;
    logic [NUM_CLK-1:0]   enclk_q, enclk_d;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        filt_d    = filt_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        stage_d   = stage_q;
        staged_d  = staged_q;
        mask_d    = mask_q;
        retry_d   = retry_q;
        go_enable = 1'b0;
        tmo_inc   = (tmo_q >= TmoMax) ? tmo_q : tmo_q + TCW'(1);
        retry_inc = (retry_q >= RetryMax) ? retry_q : retry_q + RTW'(1);

        unique case (state_q)
            StRstPll: begin
                if (rst_cnt_q >= RstLast) begin
                    state_d   = StWaitLock;
                    rst_cnt_d = '0;
                    tmo_d     = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end
            StWaitLock: begin
                filt_d = '0;
                if (lock_s_q) begin
                    tmo_d = tmo_inc;
                    if (LOCK_FILT <= 1) begin
                        go_enable = 1'b1;
                    end else begin
                        state_d = StFilter;
                        filt_d  = FCW'(1);
                    end
                end else if (tmo_q >= TmoLast) begin
                    retry_d   = retry_inc;
                    state_d   = (retry_inc >= RetryMax) ? StFail : StRstPll;
                    rst_cnt_d = '0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StFilter: begin
                // The timeout keeps accumulating across filter glitches.
                tmo_d = tmo_inc;
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                    filt_d  = '0;
                end else if (filt_q >= FiltLast) begin
                    go_enable = 1'b1;
                end else begin
                    filt_d = filt_q + FCW'(1);
                end
            end
            StEnable: begin
                if (gap_q >= GapLast) begin
                    gap_d = '0;
                    if (stage_q >= StLast) begin
                        state_d = StRun;
                    end else begin
                        stage_d  = stage_q + SW'(1);
                        staged_d = staged_q | (mask_q & (NUM_CLK'(1) << stage_d));
                    end
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            StRun, StFail: ;
            default: state_d = StRstPll;
        endcase

        if (go_enable) begin
            state_d  = StEnable;
            filt_d   = '0;
            gap_d    = '0;
            stage_d  = '0;
            mask_d   = en_mask_i;
            staged_d = en_mask_i & NUM_CLK'(1);
        end

        // Lock loss starts a fresh sequence, so the retry budget is restored.
        if ((state_q == StEnable || state_q == StRun) && !lock_s_q) begin
            state_d   = StRstPll;
            rst_cnt_d = '0;
            tmo_d     = '0;
            retry_d   = '0;
        end

        if (restart_i) begin
            state_d   = StRstPll;
            rst_cnt_d = '0;
            tmo_d     = '0;
            filt_d    = '0;
            retry_d   = '0;
        end

        pll_reset_d = (state_d == StRstPll) || (state_d == StFail);
        sys_rst_d   = (state_d != StRun);
        clk_rdy_d   = (state_d == StRun);
        fail_d      = (state_d == StFail);
        enclk_d     = '0;
        if (state_d == StEnable) begin
            enclk_d = staged_d;
        end else if (state_d == StRun) begin
            enclk_d = staged_q & en_mask_i;
        end
    end

    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StRstPll;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            rst_cnt_q   <= '0;
            filt_q      <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            stage_q     <= '0;
            staged_q    <= '0;
            mask_q      <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            clk_rdy_q   <= 1'b0;
            fail_q      <= 1'b0;
            enclk_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= pll_lock_i;
            lock_s_q    <= sync1_q;
            rst_cnt_q   <= rst_cnt_d;
            filt_q      <= filt_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            stage_q     <= stage_d;
            staged_q    <= staged_d;
            mask_q      <= mask_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            clk_rdy_q   <= clk_rdy_d;
            fail_q      <= fail_d;
            enclk_q     <= enclk_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign enclk_o     = enclk_q;
    assign sys_rst_o   = sys_rst_q;
    assign clk_rdy_o   = clk_rdy_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: per-phase vector table indexed by cycles after reset
// release, plus a hand-written asynchronous-reset-during-staging sequence.
module tb_pll_lock_sequencer;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] en_mask = 3'b111;
    logic       pll_reset, sys_rst, clk_rdy, fail;
    logic [2:0] enclk;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .NUM_CLK(3), .RST_CYCLES(4), .LOCK_FILT(8), .STAGE_GAP(2),
        .LOCK_TIMEOUT(32), .MAX_RETRY(2)
    ) dut (
        .clkin_i     (clkin),
        .reset_i     (reset),
        .pll_lock_i  (pll_lock),
        .restart_i   (restart),
        .en_mask_i   (en_mask),
        .pll_reset_o (pll_reset),
        .enclk_o     (enclk),
        .sys_rst_o   (sys_rst),
        .clk_rdy_o   (clk_rdy),
        .fail_o      (fail),
        .retry_cnt_o (retry_cnt)
    );

    always #5 clkin = ~clkin;

    // t: negedges after reset release; inputs are applied after the check at t.
    typedef struct {
        int         t;
        bit         start;
        bit         lock;
        bit         rst_in;
        logic [2:0] mask;
        bit         pr;
        logic [2:0] en;
        bit         sr;
        bit         rdy;
        bit         fl;
        logic [1:0] rc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int t, bit start, bit lock, bit rst_in, logic [2:0] mask, bit pr,
                                logic [2:0] en, bit sr, bit rdy, bit fl, logic [1:0] rc);
        vec_t v;
        v.t = t; v.start = start; v.lock = lock; v.rst_in = rst_in; v.mask = mask;
        v.pr = pr; v.en = en; v.sr = sr; v.rdy = rdy; v.fl = fl; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit pr, input logic [2:0] en, input bit sr,
                           input bit rdy, input bit fl, input logic [1:0] rc);
        chk({tag, " pll_reset"}, int'(pll_reset), int'(pr));
        chk({tag, " enclk"}, int'(enclk), int'(en));
        chk({tag, " sys_rst"}, int'(sys_rst), int'(sr));
        chk({tag, " clk_rdy"}, int'(clk_rdy), int'(rdy));
        chk({tag, " fail"}, int'(fail), int'(fl));
        chk({tag, " retry_cnt"}, int'(retry_cnt), int'(rc));
    endtask

    task automatic do_reset(input logic [2:0] mask, input bit lock);
        en_mask  = mask;
        pll_lock = lock;
        restart  = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clkin);
        chk_all("reset_hold", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int ph;
        // Nominal bring-up, mask toggling in RUN, lock loss and relock.
        vecs.push_back(mk( 0, 1, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk( 3, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk( 4, 0, 0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(14, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(23, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(24, 0, 1, 0, 3'b111, 0, 3'b001, 1, 0, 0, 2'd0));
        vecs.push_back(mk(25, 0, 1, 0, 3'b111, 0, 3'b001, 1, 0, 0, 2'd0));
        vecs.push_back(mk(26, 0, 1, 0, 3'b111, 0, 3'b011, 1, 0, 0, 2'd0));
        vecs.push_back(mk(28, 0, 1, 0, 3'b111, 0, 3'b111, 1, 0, 0, 2'd0));
        vecs.push_back(mk(29, 0, 1, 0, 3'b111, 0, 3'b111, 1, 0, 0, 2'd0));
        vecs.push_back(mk(30, 0, 1, 0, 3'b011, 0, 3'b111, 0, 1, 0, 2'd0));
        vecs.push_back(mk(31, 0, 1, 0, 3'b111, 0, 3'b011, 0, 1, 0, 2'd0));
        vecs.push_back(mk(32, 0, 0, 0, 3'b111, 0, 3'b111, 0, 1, 0, 2'd0));
        vecs.push_back(mk(34, 0, 0, 0, 3'b111, 0, 3'b111, 0, 1, 0, 2'd0));
        vecs.push_back(mk(35, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(38, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(39, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(48, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(49, 0, 1, 0, 3'b111, 0, 3'b001, 1, 0, 0, 2'd0));
        vecs.push_back(mk(55, 0, 1, 0, 3'b111, 0, 3'b111, 0, 1, 0, 2'd0));
        // Filter glitch: lock high 5, low 1, high again.
        vecs.push_back(mk( 0, 1, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk( 6, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(11, 0, 0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(12, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(16, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(21, 0, 1, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(22, 0, 1, 0, 3'b111, 0, 3'b001, 1, 0, 0, 2'd0));
        vecs.push_back(mk(28, 0, 1, 0, 3'b111, 0, 3'b111, 0, 1, 0, 2'd0));
        // No lock: two timeouts end in FAIL, restart clears it.
        vecs.push_back(mk( 0, 1, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(35, 0, 0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(36, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd1));
        vecs.push_back(mk(39, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd1));
        vecs.push_back(mk(40, 0, 0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd1));
        vecs.push_back(mk(71, 0, 0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd1));
        vecs.push_back(mk(72, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 1, 2'd2));
        vecs.push_back(mk(80, 0, 0, 1, 3'b111, 1, 3'b000, 1, 0, 1, 2'd2));
        vecs.push_back(mk(81, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(84, 0, 0, 0, 3'b111, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(85, 0, 0, 0, 3'b111, 0, 3'b000, 1, 0, 0, 2'd0));
        // Masked staging and live mask in RUN.
        vecs.push_back(mk( 0, 1, 0, 0, 3'b101, 1, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(14, 0, 1, 0, 3'b101, 0, 3'b000, 1, 0, 0, 2'd0));
        vecs.push_back(mk(24, 0, 1, 0, 3'b101, 0, 3'b001, 1, 0, 0, 2'd0));
        vecs.push_back(mk(26, 0, 1, 0, 3'b101, 0, 3'b001, 1, 0, 0, 2'd0));
        vecs.push_back(mk(28, 0, 1, 0, 3'b101, 0, 3'b101, 1, 0, 0, 2'd0));
        vecs.push_back(mk(30, 0, 1, 0, 3'b001, 0, 3'b101, 0, 1, 0, 2'd0));
        vecs.push_back(mk(31, 0, 1, 0, 3'b101, 0, 3'b001, 0, 1, 0, 2'd0));
        vecs.push_back(mk(32, 0, 1, 0, 3'b101, 0, 3'b101, 0, 1, 0, 2'd0));

        t  = 0;
        ph = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].start) begin
                ph++;
                do_reset(vecs[i].mask, vecs[i].lock);
                t = 0;
            end else begin
                while (t < vecs[i].t) begin
                    @(negedge clkin);
                    t++;
                end
            end
            chk_all($sformatf("ph%0d t%0d", ph, t), vecs[i].pr, vecs[i].en, vecs[i].sr,
                    vecs[i].rdy, vecs[i].fl, vecs[i].rc);
            pll_lock = vecs[i].lock;
            restart  = vecs[i].rst_in;
            en_mask  = vecs[i].mask;
        end

        // Asynchronous reset while staging (enclk=011) must act before the next clock edge.
        do_reset(3'b111, 1'b0);
        repeat (14) @(negedge clkin);
        pll_lock = 1'b1;
        repeat (12) @(negedge clkin);
        chk("async_pre enclk", int'(enclk), 3);
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clkin);
        reset = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Supervises a PLL primitive: PLL reset pulse, lock synchronisation and filtering, staged gating of up to NUM_CLK output-clock enables, lock-loss recovery with bounded retries. Sits beside the core PLL wrapper, runs from the PLL reference input clock, drives the PLL reset and ENCLKn pins, and produces a system reset for downstream logic. It generalises the fixed five-enable PLL hookup to a parametrised, self-sequencing controller.

Parameters:
NUM_CLK, 5, number of PLL output enables driven (1..7)
RST_CYCLES, 16, PLL reset pulse length in clkin cycles (>=1)
LOCK_FILT, 64, consecutive synchronised-lock cycles required before enabling
STAGE_GAP, 8, clkin cycles between successive enable stages (>=1)
LOCK_TIMEOUT, 65536, max cycles waiting for lock after a reset pulse
MAX_RETRY, 3, reset attempts before FAIL (>=1)

Ports:
clkin  input  1  reference clock; single clock domain
reset  input  1  asynchronous active-high reset
pll_lock  input  1  raw PLL lock; asynchronous, 2-flop synchronised internally (lock_s)
restart  input  1  synchronous pulse; forces full re-sequence from any state
en_mask  input  NUM_CLK  per-output enable permission
pll_reset  output  1  to PLL RESET
enclk  output  NUM_CLK  to PLL ENCLKn; bit i gates clkout i
sys_rst  output  1  active-high reset for downstream logic
clk_rdy  output  1  high in RUN
fail  output  1  high in FAIL
retry_cnt  output  clog2(MAX_RETRY+1)  attempts consumed in current sequence

Behaviour:
- Async reset: state=RST_PLL, pll_reset=1, enclk=0, sys_rst=1, clk_rdy=0, fail=0, retry_cnt=0, all counters 0, sync flops 0.
- All outputs registered; lock_s lags pll_lock by 2 cycles.
- RST_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK; timeout counter cleared on that transition.
- WAIT_LOCK: pll_reset=0. lock_s=1 -> FILTER. Timeout counter reaching LOCK_TIMEOUT with lock_s=0 -> retry_cnt+1; if new value == MAX_RETRY -> FAIL, else -> RST_PLL.
- FILTER: counts consecutive lock_s=1 cycles; count == LOCK_FILT -> ENABLE (stage index 0, en_mask captured). lock_s=0 -> WAIT_LOCK, filter count cleared, timeout counter NOT cleared (continues accumulating).
- ENABLE: stage i (0..NUM_CLK-1) sets enclk[i]=captured_mask[i]. Each stage lasts STAGE_GAP cycles, including masked stages. After the last stage -> RUN. Total ENABLE time = NUM_CLK*STAGE_GAP cycles.
- RUN: clk_rdy=1, sys_rst=0 from the first RUN cycle. enclk = staged bits AND live en_mask. Clearing a mask bit drops its enclk the next cycle. Setting it re-raises enclk the next cycle.
- Lock loss (lock_s=0 in ENABLE or RUN): next cycle enclk=0, sys_rst=1, clk_rdy=0 -> RST_PLL. retry_cnt cleared, because this is a new sequence.
- restart=1 in any state (including FAIL): next cycle -> RST_PLL with enclk=0, sys_rst=1, retry_cnt=0, fail=0. restart wins over any simultaneous lock event or timeout.
- FAIL: pll_reset=1, enclk=0, sys_rst=1, fail=1. Held until restart or reset.
- sys_rst=1 in every state except RUN.
- pll_reset=1 only in RST_PLL and FAIL.
- Counters saturate and do not wrap; widths are clog2 of each parameter + 1.
- Reset mid-sequence: immediate return to the reset values, asynchronously.

Test Plan:
(Params for all: NUM_CLK=3, RST_CYCLES=4, LOCK_FILT=8, STAGE_GAP=2, LOCK_TIMEOUT=32, MAX_RETRY=2, en_mask=3'b111.)
- Nominal: release reset, raise pll_lock 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; enclk goes 001,011,111 at 2-cycle spacing starting 8 cycles after lock_s rises; sys_rst falls and clk_rdy rises 6 cycles after the first enable.
- Filter glitch: pll_lock high 5 cycles, low 1, then high -> no enable until 8 consecutive lock_s cycles; timeout counter continues, no retry if total wait < 32.
- Timeout/fail: pll_lock held 0 -> two 4-cycle reset pulses, retry_cnt 1 then 2, fail=1, pll_reset=1, enclk=000; restart pulse -> fail=0, retry_cnt=0, new 4-cycle pulse.
- Lock loss in RUN: drop pll_lock -> 2 cycles sync + 1 cycle: enclk=000, sys_rst=1, pll_reset pulse; relock -> full sequence repeats.
- Masking: en_mask=3'b101 -> enclk 001,001,101 during staging; in RUN clear bit 2 -> enclk=001 next cycle, restore -> 101.
- Async reset during ENABLE (enclk=011) -> outputs return to reset values without waiting for a clkin edge.
